// File: rtl/mem_write_queue_pkg.sv
// Shared definitions for the decoder-to-memory write buffer: drain FSM encoding,
// the packed write-entry layout and the default bus widths.
package mem_write_queue_pkg;

   localparam int DEFAULT_ADDRESS_SIZE = 16;
   localparam int DEFAULT_DATA_SIZE    = 32;
   localparam int DEFAULT_DEPTH        = 4;
   localparam int DEFAULT_GAP_CYCLES   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } drain_state_e;

   // Address sits in the upper bits so {address, data} concatenations line up with this type.
   typedef struct packed {
      logic [DEFAULT_ADDRESS_SIZE-1:0] address;
      logic [DEFAULT_DATA_SIZE-1:0]    data;
   } write_entry_t;

   function automatic int entry_width(input int address_size, input int data_size);
      return address_size + data_size;
   endfunction

endpackage

// File: rtl/mem_write_queue_if.sv
// Decoder-side write strobe and memory-side replay bus of the write buffer.
// The slave modport is the queue's view; master is the decoder/memory environment.
interface mem_write_queue_if
   import mem_write_queue_pkg::*;
#(
   parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
   parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
   parameter int DEPTH        = DEFAULT_DEPTH
);

   logic                      start_in;
   logic [ADDRESS_SIZE-1:0]   address_in;
   logic [DATA_SIZE-1:0]      data_in;
   logic                      full;
   logic                      start_for_memory;
   logic [ADDRESS_SIZE-1:0]   address_for_memory;
   logic [DATA_SIZE-1:0]      data_for_memory;
   logic [$clog2(DEPTH):0]    count;
   logic                      overflow;
   logic [7:0]                drop_count;
   logic                      idle;

   modport slave (
      input  start_in,
      input  address_in,
      input  data_in,
      output full,
      output start_for_memory,
      output address_for_memory,
      output data_for_memory,
      output count,
      output overflow,
      output drop_count,
      output idle
   );

   modport master (
      output start_in,
      output address_in,
      output data_in,
      input  full,
      input  start_for_memory,
      input  address_for_memory,
      input  data_for_memory,
      input  count,
      input  overflow,
      input  drop_count,
      input  idle
   );

endinterface

// File: rtl/mem_write_queue_sync_fifo.sv
// Circular FIFO holding queued write entries; the read port is registered and
// its register doubles as the memory-facing address/data holding register.
module mem_write_queue_sync_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW:0]      count_reg;
   logic [PW:0]      count_next;
   logic [WIDTH-1:0] pop_data_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count_reg != FULL_COUNT);
   assign do_pop  = pop && (count_reg != '0);

   // Storage carries no reset so it can map onto RAM; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         pop_data_reg <= '0;
      end else begin
         count_reg <= count_next;
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            pop_data_reg <= mem_reg[rd_ptr_reg];
            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
         end
      end
   end

   assign pop_data = pop_data_reg;
   assign count    = count_reg;
   assign full     = (count_reg == FULL_COUNT);
   assign empty    = (count_reg == '0);

endmodule

// File: rtl/mem_write_queue.sv
// Write buffer between decoder and data memory: accepts one write per strobe,
// replays queued writes at one strobe per 1+GAP_CYCLES cycles, and counts drops.
module mem_write_queue
   import mem_write_queue_pkg::*;
#(
   parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
   parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
   parameter int DEPTH        = DEFAULT_DEPTH,
   parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   mem_write_queue_if.slave   bus
);

   localparam int ENTRY_W = entry_width(ADDRESS_SIZE, DATA_SIZE);
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   drain_state_e     state_reg;
   drain_state_e     state_next;
   logic [GAP_W-1:0] gap_reg;
   logic [GAP_W-1:0] gap_next;
   logic             start_reg;
   logic             start_next;
   logic             overflow_reg;
   logic [7:0]       drop_count_reg;

   logic             push;
   logic             drop;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [ENTRY_W-1:0] head;

   // A strobe seen while full is lost even if the drain frees a slot on the same edge.
   assign push = bus.start_in && !fifo_full;
   assign drop = bus.start_in && fifo_full;

   mem_write_queue_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (push),
      .push_data ({bus.address_in, bus.data_in}),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_next = state_reg;
      gap_next   = gap_reg;
      pop        = 1'b0;
      start_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               start_next = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_next = ST_GAP;
            gap_next   = GAP_LOAD;
         end
         ST_GAP: begin
            // Back-to-back issue straight from GAP keeps the sustained 1+GAP_CYCLES rate.
            if (gap_reg == '0) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  start_next = 1'b1;
                  state_next = ST_ISSUE;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               gap_next = gap_reg - 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         gap_reg   <= '0;
         start_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         gap_reg   <= gap_next;
         start_reg <= start_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_reg   <= 1'b0;
         drop_count_reg <= '0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
         if (drop_count_reg != 8'hFF) begin
            drop_count_reg <= drop_count_reg + 1'b1;
         end
      end
   end

   assign bus.full               = fifo_full;
   assign bus.count              = fifo_count;
   assign bus.start_for_memory   = start_reg;
   assign bus.address_for_memory = head[ENTRY_W-1:DATA_SIZE];
   assign bus.data_for_memory    = head[DATA_SIZE-1:0];
   assign bus.overflow           = overflow_reg;
   assign bus.drop_count         = drop_count_reg;
   assign bus.idle               = fifo_empty && (state_reg == ST_IDLE);

endmodule
